// File: rtl/axi_wr_route_ctrl_if.sv
// Write-path bundle between the master port, the two slave ports and the
// routing controller: AW/W/B handshakes plus demux/mux select and enable lines.
interface axi_wr_route_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  // Handshake rule on every channel: a transfer happens on a rising clock edge
  // where VALID and READY are both 1. VALID never waits for READY.
  logic                  M_AWVALID;
  logic [ADDR_WIDTH-1:0] M_AWADDR;
  logic                  M_AWREADY;
  logic                  S1_AWREADY;
  logic                  S2_AWREADY;
  logic                  M_WVALID;
  logic                  M_WLAST;
  logic                  M_WREADY;
  logic                  S1_WREADY;
  logic                  S2_WREADY;
  logic                  S1_BVALID;
  logic                  S2_BVALID;
  logic                  M_BREADY;
  logic                  M_BVALID;
  logic                  aw_sel;
  logic                  aw_en;
  logic                  w_sel;
  logic                  w_en;
  logic                  b_sel;
  logic                  b_en;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  busy;

  // Controller side.
  modport slave (
    input  M_AWVALID, M_AWADDR, S1_AWREADY, S2_AWREADY,
    input  M_WVALID, M_WLAST, S1_WREADY, S2_WREADY,
    input  S1_BVALID, S2_BVALID, M_BREADY,
    output M_AWREADY, M_WREADY, M_BVALID,
    output aw_sel, aw_en, w_sel, w_en, b_sel, b_en,
    output beat_cnt, busy
  );

  // Environment side: master port, slave ports and demux/mux paths.
  modport master (
    output M_AWVALID, M_AWADDR, S1_AWREADY, S2_AWREADY,
    output M_WVALID, M_WLAST, S1_WREADY, S2_WREADY,
    output S1_BVALID, S2_BVALID, M_BREADY,
    input  M_AWREADY, M_WREADY, M_BVALID,
    input  aw_sel, aw_en, w_sel, w_en, b_sel, b_en,
    input  beat_cnt, busy
  );
endinterface

// File: rtl/axi_wr_route_ctrl.sv
// Write-path routing controller for a 1-master / 2-slave AXI interconnect:
// decodes AW, then walks AW -> W -> B for one transaction at a time.
module axi_wr_route_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SPLIT_ADDR = 32'h0000_8000,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_wr_route_ctrl_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic                 sel_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic aw_en;
  logic w_en;
  logic b_en;
  logic awready;
  logic wready;
  logic bvalid;
  logic w_hs;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      // Address is decoded once in IDLE and held for the whole transaction.
      if (state_q == IDLE && bus.M_AWVALID) begin
        sel_q <= (bus.M_AWADDR >= SPLIT_ADDR);
        cnt_q <= '0;
      end else if (w_hs && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    aw_en     = 1'b0;
    w_en      = 1'b0;
    b_en      = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.M_AWVALID) state_nxt = ADDR;
      end
      ADDR: begin
        aw_en   = 1'b1;
        awready = sel_q ? bus.S2_AWREADY : bus.S1_AWREADY;
        if (bus.M_AWVALID && awready) state_nxt = DATA;
      end
      DATA: begin
        w_en   = 1'b1;
        wready = sel_q ? bus.S2_WREADY : bus.S1_WREADY;
        if (bus.M_WVALID && wready && bus.M_WLAST) state_nxt = RESP;
      end
      RESP: begin
        b_en   = 1'b1;
        bvalid = sel_q ? bus.S2_BVALID : bus.S1_BVALID;
        if (bvalid && bus.M_BREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wready is only ever non-zero in DATA, so this is the DATA-state beat.
  assign w_hs = bus.M_WVALID && wready;

  assign bus.M_AWREADY = awready;
  assign bus.M_WREADY  = wready;
  assign bus.M_BVALID  = bvalid;
  assign bus.aw_en     = aw_en;
  assign bus.w_en      = w_en;
  assign bus.b_en      = b_en;
  // Selects track sel_q in every state so idle demuxes never see a toggle.
  assign bus.aw_sel    = sel_q;
  assign bus.w_sel     = sel_q;
  assign bus.b_sel     = sel_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
